ic74138_scan_ctrl: RTL and testbench
====================================

Name: ic74138_scan_ctrl

Overview:
- Sequencer directly upstream of the ic74138 3-to-8 decoder; drives its enables (g1, g2a, g2b) and select lines.
- Scans channels 0..NUM_CH-1 with a programmable dwell per channel and a blanking gap between channels.
- During the gap all decoder outputs are forced high (inactive), preventing ghosting on LED/digit-drive and row-strobe loads.
- Supports continuous and one-shot (single-frame) modes with start/stop control.

Parameters:
- DWELL_CYCLES, 1000, clock cycles the decoder stays enabled per channel (>=1).
- BLANK_CYCLES, 16, clock cycles the decoder is disabled between channels (>=2).
- NUM_CH, 8, channels scanned per frame (1..8); select wraps NUM_CH-1 -> 0.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  pulse; begin scanning (sampled in IDLE only).
- stop_i  in  1  pulse; request stop after current channel's dwell.
- oneshot_i  in  1  mode, sampled with start_i: 1 = single frame, 0 = continuous.
- g1_o  out  1  decoder enable, active-high (to ic74138 g1_i).
- g2a_o  out  1  decoder enable, active-low (to g2a_i).
- g2b_o  out  1  decoder enable, active-low (to g2b_i).
- select_o  out  3  channel select (to select_i).
- busy_o  out  1  high whenever state != IDLE.
- frame_done_o  out  1  one-cycle pulse after channel NUM_CH-1 completes its dwell.

Behaviour:
- Clock is clk_i; reset is rst_i, synchronous, active-high. Single clock domain.
- All outputs are registered. Enables are either ON (g1=1, g2a=0, g2b=0) or OFF (g1=0, g2a=1, g2b=1).
- Reset values: state IDLE, enables OFF, select_o=0, busy_o=0, frame_done_o=0, stop-pending=0, mode=continuous.
- IDLE:
  - Enables OFF; select_o holds its last value.
  - start_i=1 and stop_i=0: latch oneshot_i, next channel = 0, enter BLANK.
  - start_i and stop_i together: stay IDLE.
- BLANK (exactly BLANK_CYCLES cycles, enables OFF):
  - select_o loads the next channel on the edge ending the first BLANK cycle, so select never changes while enables are ON.
  - After the last BLANK cycle, enter DWELL.
- DWELL (exactly DWELL_CYCLES cycles, enables ON). At the end of the last cycle:
  - If select_o == NUM_CH-1: pulse frame_done_o (high during the first cycle of the following state).
  - If stop pending, or (one-shot and select_o == NUM_CH-1): enter IDLE with enables OFF, clear stop-pending.
  - Otherwise: next channel = (select_o == NUM_CH-1) ? 0 : select_o+1, and enter BLANK.
- Latency: start_i sampled at edge k -> enables ON from edge k+BLANK_CYCLES. Channel period = BLANK_CYCLES+DWELL_CYCLES; frame = NUM_CH × period.
- stop_i:
  - In BLANK or DWELL: sets stop-pending. Stop is honoured at the end of the current or next DWELL; the active channel always completes its dwell.
  - In IDLE: ignored.
- start_i while busy: ignored; the mode latch is unchanged.
- Reset asserted in any state: reset values appear on the next edge, and enables go OFF immediately at that edge.
- Counters are sized with $clog2 of the parameter +1 so they never overflow.

Optional Feature:
- Macro: SCAN_FRAME_CNT_EN.
- Defined: adds output port frame_cnt_o [15:0], reset to 0. It increments in the same cycle frame_done_o is high and wraps 16'hFFFF -> 0. It is not cleared by stop or start.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan (DWELL_CYCLES=4, BLANK_CYCLES=2, NUM_CH=8; ic74138 instantiated downstream):
- Reset with start_i=1 -> enables OFF, select_o=0, busy_o=0, decoder outputs 8'b1111_1111.
- Continuous start at edge k -> enables ON at k+2. select_o sequence 0..7 then 0, one channel per 6 cycles. Decoder shows 8'b1111_1110 ... 8'b0111_1111, each for 4 cycles separated by 2 cycles of 8'hFF. frame_done_o pulses once per 48 cycles. Check select_o never changes while g1_o=1.
- One-shot start -> exactly one frame. frame_done_o pulses, busy_o falls in the same cycle, select_o holds 7, decoder stays 8'hFF.
- stop_i during channel 3 dwell -> channel 3 completes its 4 cycles, then IDLE with select_o=3 and no frame_done_o. A new start then begins again at channel 0.
- Corner cases:
  - start_i+stop_i together in IDLE -> stays IDLE.
  - start_i while busy -> no effect.
  - NUM_CH=5 -> select_o wraps 4 -> 0.
- rst_i pulsed mid-DWELL on channel 5 -> the next cycle shows reset values (decoder 8'hFF). With SCAN_FRAME_CNT_EN: frame_cnt_o returns to 0 and increments once per completed frame.

Source files
------------

// File: rtl/ic74138_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ic74138_scan_ctrl
//
// Scan sequencer that sits directly in front of an ic74138 3-to-8 decoder.
// It steps the decoder select through channels 0..NUM_CH-1. Each channel is
// enabled for DWELL_CYCLES clocks. Between channels the decoder is disabled
// for BLANK_CYCLES clocks, so all decoder outputs sit high. This blanking gap
// prevents ghosting on digit-drive and row-strobe loads.
//
// The scan runs either continuously or for a single frame (one-shot). It is
// controlled by start and stop pulses.
//
// State table
//   state | meaning
//   IDLE  | not scanning, enables OFF, select holds its last value
//   BLANK | enables OFF; select takes the next channel after the first cycle
//   DWELL | enables ON for the selected channel
//
// Parameters
//   DWELL_CYCLES  clocks the decoder stays enabled per channel (>= 1)
//   BLANK_CYCLES  clocks the decoder is disabled between channels (>= 2)
//   NUM_CH        channels per frame (1..8); select wraps NUM_CH-1 -> 0
//
// Ports
//   clk_i         clock, all logic on the rising edge
//   rst_i         synchronous reset, active-high
//   start_i       pulse, begins a scan (only accepted in IDLE without stop_i)
//   stop_i        pulse, stops after the current channel's dwell
//   oneshot_i     mode, captured with start_i: 1 = single frame, 0 = continuous
//   g1_o          decoder enable, active-high
//   g2a_o         decoder enable, active-low
//   g2b_o         decoder enable, active-low
//   select_o[2:0] decoder channel select
//   busy_o        high whenever the sequencer is not in IDLE
//   frame_done_o  one-cycle pulse after the last channel's dwell ends
//   frame_cnt_o   (SCAN_FRAME_CNT_EN only) 16-bit wrapping count of frames
//
// Build option
//   SCAN_FRAME_CNT_EN  when defined, adds the frame_cnt_o port and its counter
// ---------------------------------------------------------------------------
module ic74138_scan_ctrl #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int NUM_CH       = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        oneshot_i,
  output logic        g1_o,
  output logic        g2a_o,
  output logic        g2b_o,
  output logic [2:0]  select_o,
  output logic        busy_o,
  output logic        frame_done_o
`ifdef SCAN_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt_o
`endif
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // The same down-counter times both BLANK and DWELL. It is loaded with
  // length-1, and the phase ends on the cycle where the counter reads zero.
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [2:0]       LAST_CH    = 3'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DWELL = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       sel, sel_nxt;
  logic [2:0]       next_ch, next_ch_nxt;
  logic             en, en_nxt;
  logic             busy, busy_nxt;
  logic             frame_done, frame_done_nxt;
  logic             stop_pend, stop_pend_nxt;
  logic             oneshot, oneshot_nxt;
  logic             last_ch;

`ifdef SCAN_FRAME_CNT_EN
  logic [15:0]      frame_cnt, frame_cnt_nxt;
`endif

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= 3'd0;
      next_ch    <= 3'd0;
      en         <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      stop_pend  <= 1'b0;
      oneshot    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sel        <= sel_nxt;
      next_ch    <= next_ch_nxt;
      en         <= en_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
      stop_pend  <= stop_pend_nxt;
      oneshot    <= oneshot_nxt;
    end
  end

  assign last_ch = (sel == LAST_CH);

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    sel_nxt        = sel;
    next_ch_nxt    = next_ch;
    en_nxt         = en;
    frame_done_nxt = 1'b0;
    stop_pend_nxt  = stop_pend;
    oneshot_nxt    = oneshot;

    case (state)
      IDLE: begin
        en_nxt        = 1'b0;
        stop_pend_nxt = 1'b0;
        // A start that arrives together with a stop is treated as cancelled.
        if (start_i && !stop_i) begin
          oneshot_nxt = oneshot_i;
          next_ch_nxt = 3'd0;
          cnt_nxt     = BLANK_LOAD;
          state_nxt   = BLANK;
        end
      end

      BLANK: begin
        en_nxt = 1'b0;
        if (stop_i) begin
          stop_pend_nxt = 1'b1;
        end
        // The select changes only after the enables have been OFF for one
        // full cycle, so the decoder never glitches through another channel.
        if (cnt == BLANK_LOAD) begin
          sel_nxt = next_ch;
        end
        if (cnt == CNT_ZERO) begin
          cnt_nxt   = DWELL_LOAD;
          en_nxt    = 1'b1;
          state_nxt = DWELL;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      DWELL: begin
        en_nxt = 1'b1;
        if (stop_i) begin
          stop_pend_nxt = 1'b1;
        end
        if (cnt == CNT_ZERO) begin
          frame_done_nxt = last_ch;
          en_nxt         = 1'b0;
          // A stop that arrives on the final dwell cycle is honoured at once.
          if (stop_pend || stop_i || (oneshot && last_ch)) begin
            stop_pend_nxt = 1'b0;
            state_nxt     = IDLE;
          end else begin
            next_ch_nxt = last_ch ? 3'd0 : sel + 3'd1;
            cnt_nxt     = BLANK_LOAD;
            state_nxt   = BLANK;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      default: begin
        en_nxt        = 1'b0;
        stop_pend_nxt = 1'b0;
        state_nxt     = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

`ifdef SCAN_FRAME_CNT_EN
  // Updated at the same edge that raises frame_done_o. It is cleared only
  // by reset and wraps naturally at 16 bits.
  always_comb begin
    frame_cnt_nxt = frame_cnt;
    if (frame_done_nxt) begin
      frame_cnt_nxt = frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_cnt <= 16'd0;
    end else begin
      frame_cnt <= frame_cnt_nxt;
    end
  end

  assign frame_cnt_o = frame_cnt;
`endif

  assign g1_o         = en;
  assign g2a_o        = ~en;
  assign g2b_o        = ~en;
  assign select_o     = sel;
  assign busy_o       = busy;
  assign frame_done_o = frame_done;

endmodule

// File: tb/tb_ic74138_scan_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for ic74138_scan_ctrl.
//
// Main DUT: DWELL=4, BLANK=2, NUM_CH=8. A second DUT uses NUM_CH=5 to
// exercise the select wrap.
//
// Timing convention: inputs are driven and outputs sampled 1ns after the
// rising edge. t=0 is the sample taken just after the edge that captured
// start_i. With a 6-cycle channel period:
//   phase 0,1 : BLANK (select updates at phase 1)
//   phase 2..5: DWELL
// ---------------------------------------------------------------------------
module tb_ic74138_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;

  logic       start_i = 1'b0, stop_i = 1'b0, oneshot_i = 1'b0;
  logic       g1_o, g2a_o, g2b_o, busy_o, frame_done_o;
  logic [2:0] select_o;

  logic       s5_start = 1'b0, s5_stop = 1'b0, s5_oneshot = 1'b0;
  logic       s5_g1, s5_g2a, s5_g2b, s5_busy, s5_fd;
  logic [2:0] s5_sel;

`ifdef SCAN_FRAME_CNT_EN
  logic [15:0] frame_cnt_o;
  logic [15:0] s5_frame_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] last_sel = 3'd0;

  always #5 clk = ~clk;

  ic74138_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .NUM_CH(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .oneshot_i(oneshot_i), .g1_o(g1_o), .g2a_o(g2a_o), .g2b_o(g2b_o),
    .select_o(select_o), .busy_o(busy_o), .frame_done_o(frame_done_o)
`ifdef SCAN_FRAME_CNT_EN
    , .frame_cnt_o(frame_cnt_o)
`endif
  );

  ic74138_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .NUM_CH(5)) dut5 (
    .clk_i(clk), .rst_i(rst_i), .start_i(s5_start), .stop_i(s5_stop),
    .oneshot_i(s5_oneshot), .g1_o(s5_g1), .g2a_o(s5_g2a), .g2b_o(s5_g2b),
    .select_o(s5_sel), .busy_o(s5_busy), .frame_done_o(s5_fd)
`ifdef SCAN_FRAME_CNT_EN
    , .frame_cnt_o(s5_frame_cnt)
`endif
  );

  // Behavioural ic74138: active-low outputs, all high unless fully enabled
  function automatic logic [7:0] dec(input logic g1, input logic g2a,
                                     input logic g2b, input logic [2:0] s);
    if (g1 && !g2a && !g2b) return ~(8'd1 << s);
    return 8'hFF;
  endfunction

  // Expected {frame_done, g1, g2a, g2b, select} at sample t of a running scan
  function automatic logic [6:0] model(input int t, input int n, input logic [2:0] prev);
    int ch;
    int ph;
    logic [2:0] s;
    logic en;
    logic fd;
    ch = (t / 6) % n;
    ph = t % 6;
    if (ph == 0) s = (t == 0) ? prev : 3'((ch + n - 1) % n);
    else         s = 3'(ch);
    en = (ph >= 2);
    fd = (t > 0) && ((t % (6 * n)) == 0);
    return {fd, en, ~en, ~en, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b1; s5_start = 1'b1;
    tick(); tick();
    n_checks++;
    if ({frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o} !== 8'b0_011_000_0)
      $display("FAIL reset_outputs: got %b expected %b",
               {frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o}, 8'b0_011_000_0);
    else n_pass++;
    n_checks++;
    if (dec(g1_o, g2a_o, g2b_o, select_o) !== 8'hFF)
      $display("FAIL reset_decoder: got %h expected ff", dec(g1_o, g2a_o, g2b_o, select_o));
    else n_pass++;
    n_checks++;
    if ({s5_busy, s5_g1, s5_sel} !== 5'b0_0_000)
      $display("FAIL reset_dut5: got %b expected 00000", {s5_busy, s5_g1, s5_sel});
    else n_pass++;
`ifdef SCAN_FRAME_CNT_EN
    n_checks++;
    if (frame_cnt_o !== 16'd0)
      $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt_o);
    else n_pass++;
`endif
    rst_i = 1'b0; start_i = 1'b0; s5_start = 1'b0;
    tick();
    last_sel = 3'd0;
  endtask

  task automatic test_continuous();
    logic [6:0] e;
    int fd_cnt;
    fd_cnt = 0;
    oneshot_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int t = 0; t <= 96; t++) begin
      e = model(t, 8, last_sel);
      n_checks++;
      if ({frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o} !== {e, 1'b1})
        $display("FAIL cont_t%0d: got %b expected %b", t,
                 {frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o}, {e, 1'b1});
      else n_pass++;
      n_checks++;
      if (dec(g1_o, g2a_o, g2b_o, select_o) !== dec(e[5], e[4], e[3], e[2:0]))
        $display("FAIL cont_dec_t%0d: got %h expected %h", t,
                 dec(g1_o, g2a_o, g2b_o, select_o), dec(e[5], e[4], e[3], e[2:0]));
      else n_pass++;
      if (frame_done_o) fd_cnt++;
      if (t < 96) tick();
    end
    n_checks++;
    if (fd_cnt != 2) $display("FAIL cont_frame_pulses: got %0d expected 2", fd_cnt);
    else n_pass++;
    // t=96 is BLANK of channel 0, so this stop ends the scan after channel 0
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    for (int i = 0; i < 40 && busy_o; i++) tick();
    n_checks++;
    if ({busy_o, g1_o, select_o, frame_done_o} !== {1'b0, 1'b0, 3'd0, 1'b0})
      $display("FAIL cont_stop_idle: got %b expected 000000",
               {busy_o, g1_o, select_o, frame_done_o});
    else n_pass++;
    last_sel = 3'd0;
  endtask

  task automatic test_oneshot(input logic restart_mid);
    logic [6:0] e;
    oneshot_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int t = 0; t < 48; t++) begin
      e = model(t, 8, last_sel);
      n_checks++;
      if ({frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o} !== {e, 1'b1})
        $display("FAIL oneshot%0d_t%0d: got %b expected %b", restart_mid, t,
                 {frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o}, {e, 1'b1});
      else n_pass++;
      // A continuous-mode start while busy must leave the one-shot latch alone
      if (restart_mid && t == 10) begin
        start_i = 1'b1; oneshot_i = 1'b0;
      end
      tick();
      start_i = 1'b0;
    end
    n_checks++;
    if ({frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o} !== 8'b1_011_111_0)
      $display("FAIL oneshot%0d_end: got %b expected %b", restart_mid,
               {frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o}, 8'b1_011_111_0);
    else n_pass++;
    tick();
    n_checks++;
    if ({frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o} !== 8'b0_011_111_0)
      $display("FAIL oneshot%0d_hold: got %b expected %b", restart_mid,
               {frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o}, 8'b0_011_111_0);
    else n_pass++;
    n_checks++;
    if (dec(g1_o, g2a_o, g2b_o, select_o) !== 8'hFF)
      $display("FAIL oneshot%0d_dec: got %h expected ff", restart_mid,
               dec(g1_o, g2a_o, g2b_o, select_o));
    else n_pass++;
    last_sel = 3'd7;
  endtask

  task automatic test_stop();
    logic [6:0] e;
    oneshot_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int t = 0; t < 24; t++) begin
      e = model(t, 8, last_sel);
      n_checks++;
      if ({frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o} !== {e, 1'b1})
        $display("FAIL stop_t%0d: got %b expected %b", t,
                 {frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o}, {e, 1'b1});
      else n_pass++;
      if (t == 21) stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o} !== 8'b0_011_011_0)
        $display("FAIL stop_idle%0d: got %b expected %b", k,
                 {frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o}, 8'b0_011_011_0);
      else n_pass++;
      tick();
    end
    last_sel = 3'd3;
    // Restart begins again at channel 0
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int t = 0; t < 8; t++) begin
      e = model(t, 8, last_sel);
      n_checks++;
      if ({frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o} !== {e, 1'b1})
        $display("FAIL restart_t%0d: got %b expected %b", t,
                 {frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o}, {e, 1'b1});
      else n_pass++;
      if (t == 7) stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
    end
    for (int i = 0; i < 40 && busy_o; i++) tick();
    n_checks++;
    if ({busy_o, g1_o, select_o} !== {1'b0, 1'b0, 3'd1})
      $display("FAIL restart_stop_idle: got %b expected 00001", {busy_o, g1_o, select_o});
    else n_pass++;
    last_sel = 3'd1;
  endtask

  task automatic test_start_stop_together();
    start_i = 1'b1; stop_i = 1'b1; oneshot_i = 1'b0;
    tick();
    start_i = 1'b0; stop_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({busy_o, g1_o, g2a_o, g2b_o, select_o} !== {4'b0011, last_sel})
        $display("FAIL start_stop_idle%0d: got %b expected %b", k,
                 {busy_o, g1_o, g2a_o, g2b_o, select_o}, {4'b0011, last_sel});
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_wrap5();
    logic [6:0] e;
    s5_oneshot = 1'b0; s5_start = 1'b1;
    tick();
    s5_start = 1'b0;
    for (int t = 0; t <= 36; t++) begin
      e = model(t, 5, 3'd0);
      n_checks++;
      if ({s5_fd, s5_g1, s5_g2a, s5_g2b, s5_sel, s5_busy} !== {e, 1'b1})
        $display("FAIL wrap5_t%0d: got %b expected %b", t,
                 {s5_fd, s5_g1, s5_g2a, s5_g2b, s5_sel, s5_busy}, {e, 1'b1});
      else n_pass++;
      if (t < 36) tick();
    end
    s5_stop = 1'b1;
    tick();
    s5_stop = 1'b0;
    for (int i = 0; i < 40 && s5_busy; i++) tick();
    n_checks++;
    if ({s5_busy, s5_g1, s5_sel} !== {1'b0, 1'b0, 3'd1})
      $display("FAIL wrap5_stop_idle: got %b expected 00001", {s5_busy, s5_g1, s5_sel});
    else n_pass++;
  endtask

  task automatic test_reset_mid_dwell();
    logic [6:0] e;
    oneshot_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int t = 0; t <= 33; t++) begin
      e = model(t, 8, last_sel);
      n_checks++;
      if ({frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o} !== {e, 1'b1})
        $display("FAIL rstmid_t%0d: got %b expected %b", t,
                 {frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o}, {e, 1'b1});
      else n_pass++;
      if (t < 33) tick();
    end
    // t=33 is the second dwell cycle of channel 5
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_checks++;
    if ({frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o} !== 8'b0_011_000_0)
      $display("FAIL rstmid_reset: got %b expected %b",
               {frame_done_o, g1_o, g2a_o, g2b_o, select_o, busy_o}, 8'b0_011_000_0);
    else n_pass++;
    n_checks++;
    if (dec(g1_o, g2a_o, g2b_o, select_o) !== 8'hFF)
      $display("FAIL rstmid_dec: got %h expected ff", dec(g1_o, g2a_o, g2b_o, select_o));
    else n_pass++;
`ifdef SCAN_FRAME_CNT_EN
    n_checks++;
    if (frame_cnt_o !== 16'd0)
      $display("FAIL rstmid_frame_cnt: got %0d expected 0", frame_cnt_o);
    else n_pass++;
`endif
    tick();
    n_checks++;
    if ({busy_o, g1_o, select_o} !== 5'b0_0_000)
      $display("FAIL rstmid_after: got %b expected 00000", {busy_o, g1_o, select_o});
    else n_pass++;
    last_sel = 3'd0;
`ifdef SCAN_FRAME_CNT_EN
    oneshot_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 60 && busy_o; i++) tick();
    n_checks++;
    if (frame_cnt_o !== 16'd1)
      $display("FAIL frame_cnt_incr: got %0d expected 1", frame_cnt_o);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_oneshot(1'b0);
    test_oneshot(1'b1);
    test_stop();
    test_start_stop_together();
    test_wrap5();
    test_reset_mid_dwell();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
